// File: rtl/sys_cmd_master_if.sv
// sys_cmd_master_if: command, TX byte stream and RX response signals of the host command initiator.
interface sys_cmd_master_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_FUN_WIDTH = 4
) ();
  logic                      CMD_VLD;
  logic                      CMD_RDY;
  logic [1:0]                CMD_TYPE;
  logic [ADDR_WIDTH-1:0]     CMD_ADDR;
  logic [DATA_WIDTH-1:0]     CMD_DATA;
  logic [DATA_WIDTH-1:0]     CMD_OPB;
  logic [ALU_FUN_WIDTH-1:0]  CMD_FUN;
  logic [DATA_WIDTH-1:0]     TX_P_DATA;
  logic                      TX_D_VLD;
  logic                      TX_BUSY;
  logic [DATA_WIDTH-1:0]     RX_P_DATA;
  logic                      RX_D_VLD;
  logic [2*DATA_WIDTH-1:0]   RSP_DATA;
  logic                      RSP_VLD;
  logic                      RSP_TIMEOUT;
  logic                      BUSY;
  modport master (
    input  CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_DATA, CMD_OPB, CMD_FUN, TX_BUSY, RX_P_DATA, RX_D_VLD,
    output CMD_RDY, TX_P_DATA, TX_D_VLD, RSP_DATA, RSP_VLD, RSP_TIMEOUT, BUSY
  );
  modport slave (
    output CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_DATA, CMD_OPB, CMD_FUN, TX_BUSY, RX_P_DATA, RX_D_VLD,
    input  CMD_RDY, TX_P_DATA, TX_D_VLD, RSP_DATA, RSP_VLD, RSP_TIMEOUT, BUSY
  );
endinterface

// File: rtl/sys_cmd_master.sv
// sys_cmd_master: serializes one command into an AA/BB/CC/DD byte frame and collects the response.
module sys_cmd_master #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int ALU_FUN_WIDTH  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic CLK,
  input logic RST,
  sys_cmd_master_if.master bus
);
  localparam int DW = DATA_WIDTH;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;
  state_t                   state_q, state_d;
  logic [1:0]               type_q, type_d, idx_q, idx_d, last_idx;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [DW-1:0]            data_q, data_d, opb_q, opb_d, hdr, fun_ext, addr_ext, tx_byte;
  logic [ALU_FUN_WIDTH-1:0] fun_q, fun_d;
  logic                     cnt_q, cnt_d, to_q, to_d;
  logic [TW-1:0]            tmr_q, tmr_d;
  logic [2*DW-1:0]          sh_q, sh_d, rsp_q, rsp_d, sh_new;
  always_comb begin
    hdr      = type_q == 2'd0 ? DW'(8'hAA) : type_q == 2'd1 ? DW'(8'hBB) : type_q == 2'd2 ? DW'(8'hCC) : DW'(8'hDD);
    fun_ext  = DW'(fun_q);
    addr_ext = DW'(addr_q);
    last_idx = type_q == 2'd0 ? 2'd2 : type_q == 2'd2 ? 2'd3 : 2'd1;
    tx_byte  = idx_q == 2'd0 ? hdr :
               idx_q == 2'd1 ? (type_q[1] ? (type_q[0] ? fun_ext : data_q) : addr_ext) :
               idx_q == 2'd2 ? (type_q[1] ? opb_q : data_q) : fun_ext;
    sh_new   = cnt_q ? {bus.RX_P_DATA, sh_q[DW-1:0]} : {sh_q[2*DW-1:DW], bus.RX_P_DATA};
  end
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    opb_d   = opb_q;
    fun_d   = fun_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    sh_d    = sh_q;
    rsp_d   = rsp_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: if (bus.CMD_VLD) begin
        state_d = SEND;
        type_d  = bus.CMD_TYPE;
        addr_d  = bus.CMD_ADDR;
        data_d  = bus.CMD_DATA;
        opb_d   = bus.CMD_OPB;
        fun_d   = bus.CMD_FUN;
        idx_d   = 2'd0;
      end
      SEND: if (!bus.TX_BUSY) begin
        idx_d = idx_q + 2'd1;
        if (idx_q == last_idx) begin
          state_d = type_q == 2'd0 ? DONE : WAIT_RSP;
          rsp_d   = type_q == 2'd0 ? '0 : rsp_q;
          cnt_d   = 1'b0;
          tmr_d   = '0;
          sh_d    = '0;
        end
      end
      WAIT_RSP: if (bus.RX_D_VLD) begin
        tmr_d = '0;
        sh_d  = sh_new;
        cnt_d = 1'b1;
        if (type_q == 2'd1 || cnt_q) begin
          state_d = DONE;
          rsp_d   = sh_new;
        end
      end else if (tmr_q == TW'(TIMEOUT_CYCLES - 2)) begin
        // terminal count is checked one early so the pulse lands TIMEOUT_CYCLES after the last activity
        state_d = IDLE;
        rsp_d   = '0;
        to_d    = 1'b1;
      end else begin
        tmr_d = tmr_q + TW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      type_q  <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      opb_q   <= '0;
      fun_q   <= '0;
      cnt_q   <= 1'b0;
      tmr_q   <= '0;
      sh_q    <= '0;
      rsp_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      opb_q   <= opb_d;
      fun_q   <= fun_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      sh_q    <= sh_d;
      rsp_q   <= rsp_d;
      to_q    <= to_d;
    end
  end
  assign bus.CMD_RDY     = state_q == IDLE;
  assign bus.TX_D_VLD    = state_q == SEND;
  assign bus.TX_P_DATA   = state_q == SEND ? tx_byte : '0;
  assign bus.RSP_DATA    = rsp_q;
  assign bus.RSP_VLD     = state_q == DONE;
  assign bus.RSP_TIMEOUT = to_q;
  assign bus.BUSY        = state_q != IDLE;
endmodule

// File: tb/tb_sys_cmd_master.sv
// tb_sys_cmd_master: table-driven frame/response vectors plus hand-written reset and spurious-input sequences.
module tb_sys_cmd_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int failed = 0;
  always #5 clk = ~clk;
  sys_cmd_master_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_FUN_WIDTH(4)) bus ();
  sys_cmd_master #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_FUN_WIDTH(4), .TIMEOUT_CYCLES(16)) dut (
    .CLK(clk), .RST(rst), .bus(bus)
  );
  typedef struct {
    logic [1:0]       typ;
    logic [3:0]       addr;
    logic [7:0]       a;
    logic [7:0]       b;
    logic [3:0]       fun;
    int               busy;
    int               nbytes;
    logic [3:0][7:0]  tx;
    int               nrx;
    logic [1:0][7:0]  rx;
    logic [15:0]      rsp;
    bit               to;
  } vec_t;
  vec_t vecs[7];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdy"}, 32'(bus.CMD_RDY), 32'd1);
    chk({tag, "_txv"}, 32'(bus.TX_D_VLD), 32'd0);
    chk({tag, "_txd"}, 32'(bus.TX_P_DATA), 32'h0);
    chk({tag, "_rsp"}, 32'(bus.RSP_DATA), 32'h0);
    chk({tag, "_vld"}, 32'(bus.RSP_VLD), 32'd0);
    chk({tag, "_to"}, 32'(bus.RSP_TIMEOUT), 32'd0);
    chk({tag, "_busy"}, 32'(bus.BUSY), 32'd0);
  endtask
  task automatic issue(input vec_t v);
    @(negedge clk);
    chk("issue_rdy", 32'(bus.CMD_RDY), 32'd1);
    bus.CMD_VLD  = 1'b1;
    bus.CMD_TYPE = v.typ;
    bus.CMD_ADDR = v.addr;
    bus.CMD_DATA = v.a;
    bus.CMD_OPB  = v.b;
    bus.CMD_FUN  = v.fun;
    @(negedge clk);
    bus.CMD_VLD  = 1'b0;
  endtask
  task automatic run_vec(input int id, input vec_t v);
    int n;
    issue(v);
    for (int i = 0; i < v.nbytes; i++) begin
      for (int k = 0; k < v.busy; k++) begin
        bus.TX_BUSY = 1'b1;
        chk($sformatf("v%0d_hold%0d_vld", id, i), 32'(bus.TX_D_VLD), 32'd1);
        chk($sformatf("v%0d_hold%0d_byte", id, i), 32'(bus.TX_P_DATA), 32'(v.tx[i]));
        @(negedge clk);
      end
      bus.TX_BUSY = 1'b0;
      chk($sformatf("v%0d_tx%0d_vld", id, i), 32'(bus.TX_D_VLD), 32'd1);
      chk($sformatf("v%0d_tx%0d_byte", id, i), 32'(bus.TX_P_DATA), 32'(v.tx[i]));
      @(negedge clk);
    end
    for (int j = 0; j < v.nrx; j++) begin
      chk($sformatf("v%0d_wait%0d_vld", id, j), 32'(bus.RSP_VLD), 32'd0);
      bus.RX_D_VLD  = 1'b1;
      bus.RX_P_DATA = v.rx[j];
      @(negedge clk);
      bus.RX_D_VLD  = 1'b0;
    end
    if (v.to) begin
      n = 1;
      while (!bus.RSP_TIMEOUT && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("v%0d_to_latency", id), 32'(n), 32'd16);
      chk($sformatf("v%0d_to_rsp", id), 32'(bus.RSP_DATA), 32'h0);
      chk($sformatf("v%0d_to_vld", id), 32'(bus.RSP_VLD), 32'd0);
    end else begin
      chk($sformatf("v%0d_rsp_vld", id), 32'(bus.RSP_VLD), 32'd1);
      chk($sformatf("v%0d_rsp_data", id), 32'(bus.RSP_DATA), 32'(v.rsp));
      chk($sformatf("v%0d_rsp_to", id), 32'(bus.RSP_TIMEOUT), 32'd0);
    end
    @(negedge clk);
    chk($sformatf("v%0d_after_rdy", id), 32'(bus.CMD_RDY), 32'd1);
    chk($sformatf("v%0d_after_vld", id), 32'(bus.RSP_VLD), 32'd0);
    chk($sformatf("v%0d_after_to", id), 32'(bus.RSP_TIMEOUT), 32'd0);
    chk($sformatf("v%0d_after_hold", id), 32'(bus.RSP_DATA), 32'(v.rsp));
  endtask
  initial begin
    vec_t v;
    vecs[0] = '{2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, 0, 3, {8'h00, 8'h3C, 8'h05, 8'hAA}, 0, {8'h00, 8'h00}, 16'h0000, 1'b0};
    vecs[1] = '{2'd1, 4'h2, 8'h00, 8'h00, 4'h0, 3, 2, {8'h00, 8'h00, 8'h02, 8'hBB}, 1, {8'h00, 8'h7E}, 16'h007E, 1'b0};
    vecs[2] = '{2'd2, 4'h0, 8'h12, 8'h34, 4'h1, 0, 4, {8'h01, 8'h34, 8'h12, 8'hCC}, 2, {8'h00, 8'h46}, 16'h0046, 1'b0};
    vecs[3] = '{2'd3, 4'h0, 8'h00, 8'h00, 4'h3, 0, 2, {8'h00, 8'h00, 8'h03, 8'hDD}, 1, {8'h00, 8'h55}, 16'h0000, 1'b1};
    vecs[4] = '{2'd2, 4'h9, 8'hFF, 8'h80, 4'hF, 1, 4, {8'h0F, 8'h80, 8'hFF, 8'hCC}, 2, {8'h5A, 8'hA5}, 16'h5AA5, 1'b0};
    vecs[5] = '{2'd1, 4'hF, 8'h11, 8'h22, 4'h7, 0, 2, {8'h00, 8'h00, 8'h0F, 8'hBB}, 1, {8'h00, 8'h81}, 16'h0081, 1'b0};
    vecs[6] = '{2'd3, 4'h0, 8'h00, 8'h00, 4'h0, 2, 2, {8'h00, 8'h00, 8'h00, 8'hDD}, 2, {8'h02, 8'h01}, 16'h0201, 1'b0};
    bus.CMD_VLD = 1'b0; bus.CMD_TYPE = '0; bus.CMD_ADDR = '0; bus.CMD_DATA = '0;
    bus.CMD_OPB = '0; bus.CMD_FUN = '0; bus.TX_BUSY = 1'b0; bus.RX_P_DATA = '0; bus.RX_D_VLD = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);
    // spurious RX in IDLE must not disturb the held response
    @(negedge clk);
    bus.RX_D_VLD = 1'b1; bus.RX_P_DATA = 8'h99;
    @(negedge clk);
    bus.RX_D_VLD = 1'b0;
    chk("idle_rx_rsp", 32'(bus.RSP_DATA), 32'h0201);
    chk("idle_rx_vld", 32'(bus.RSP_VLD), 32'd0);
    chk("idle_rx_busy", 32'(bus.BUSY), 32'd0);
    // read held in SEND while spurious RX and a competing write command arrive
    v = '{2'd1, 4'h6, 8'h00, 8'h00, 4'h0, 0, 2, {8'h00, 8'h00, 8'h06, 8'hBB}, 1, {8'h00, 8'h3C}, 16'h003C, 1'b0};
    bus.TX_BUSY = 1'b1;
    issue(v);
    bus.RX_D_VLD = 1'b1; bus.RX_P_DATA = 8'hEE;
    bus.CMD_VLD = 1'b1; bus.CMD_TYPE = 2'd0; bus.CMD_ADDR = 4'hA; bus.CMD_DATA = 8'h77;
    chk("send_rdy", 32'(bus.CMD_RDY), 32'd0);
    chk("send_busy", 32'(bus.BUSY), 32'd1);
    @(negedge clk);
    bus.RX_D_VLD = 1'b0; bus.CMD_VLD = 1'b0;
    chk("send_byte0", 32'(bus.TX_P_DATA), 32'hBB);
    bus.TX_BUSY = 1'b0;
    @(negedge clk);
    chk("send_byte1", 32'(bus.TX_P_DATA), 32'h06);
    chk("send_rsp_vld", 32'(bus.RSP_VLD), 32'd0);
    @(negedge clk);
    bus.RX_D_VLD = 1'b1; bus.RX_P_DATA = 8'h3C;
    @(negedge clk);
    bus.RX_D_VLD = 1'b0;
    chk("send_rsp_done", 32'(bus.RSP_VLD), 32'd1);
    chk("send_rsp_data", 32'(bus.RSP_DATA), 32'h003C);
    @(negedge clk);
    // reset mid-SEND abandons the CC frame
    v = '{2'd2, 4'h0, 8'hAB, 8'hCD, 4'h2, 0, 4, {8'h02, 8'hCD, 8'hAB, 8'hCC}, 2, {8'h00, 8'h00}, 16'h0000, 1'b0};
    issue(v);
    chk("rst_byte0", 32'(bus.TX_P_DATA), 32'hCC);
    @(negedge clk);
    chk("rst_byte1", 32'(bus.TX_P_DATA), 32'hAB);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("midrst");
    @(negedge clk);
    chk_reset_outputs("postrst");
    run_vec(7, vecs[5]);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/sys_cmd_master.md
# sys_cmd_master

Host-side command initiator for the system control command protocol. It accepts one command at a time and serializes it into the byte frame the system controller decodes: 0xAA write, 0xBB read, 0xCC ALU with operands, 0xDD ALU without operands. The frame goes out on a byte stream toward the UART transmitter. For read and ALU frames, the block then collects the response bytes returning from the UART receiver and presents the assembled result. It is used in the verification environment and in the host bridge, and is the counterpart of the system controller.

## Interface

Parameters:
- DATA_WIDTH, 8: byte/data width
- ADDR_WIDTH, 4: register file address width
- ALU_FUN_WIDTH, 4: ALU function code width
- TIMEOUT_CYCLES, 1024: response wait limit in cycles (≥2)

Ports:
- CLK  in  1  single clock; all logic on rising edge
- RST  in  1  synchronous active-high reset
- CMD_VLD  in  1  command request
- CMD_RDY  out  1  command accept; the command is taken on a cycle with CMD_VLD & CMD_RDY
- CMD_TYPE  in  2  00 write, 01 read, 10 ALU with operands, 11 ALU without operands
- CMD_ADDR  in  ADDR_WIDTH  register address (write/read)
- CMD_DATA  in  DATA_WIDTH  write data, or operand A
- CMD_OPB  in  DATA_WIDTH  operand B
- CMD_FUN  in  ALU_FUN_WIDTH  ALU function
- TX_P_DATA  out  DATA_WIDTH  outgoing frame byte
- TX_D_VLD  out  1  outgoing byte valid
- TX_BUSY  in  1  UART TX busy; a byte transfers on a cycle with TX_D_VLD & ~TX_BUSY
- RX_P_DATA  in  DATA_WIDTH  response byte
- RX_D_VLD  in  1  response byte strobe, one cycle per byte
- RSP_DATA  out  2*DATA_WIDTH  assembled response
- RSP_VLD  out  1  one-cycle completion pulse
- RSP_TIMEOUT  out  1  one-cycle timeout pulse
- BUSY  out  1  high whenever the FSM is not in IDLE

## Operation

- States are IDLE, SEND, WAIT_RSP and DONE.
- IDLE:
  - CMD_RDY=1.
  - On accept, CMD_* is registered into the frame registers and the FSM moves to SEND with byte index = 0.
- SEND: bytes go out in the order listed for each frame.
  - Write: 0xAA, addr, data (3 bytes).
  - Read: 0xBB, addr (2 bytes).
  - ALU with operands: 0xCC, A, B, fun (4 bytes).
  - ALU without operands: 0xDD, fun (2 bytes).
- Width rules for the SEND bytes:
  - addr and fun are zero-extended to DATA_WIDTH.
  - The byte index is 2 bits and is compared against the frame length minus 1.
- SEND handshake:
  - TX_D_VLD=1 throughout SEND.
  - TX_P_DATA is held stable while TX_BUSY=1.
  - The index advances only on a transfer.
- Leaving SEND, on the transfer of the last byte:
  - Write frame: go to DONE.
  - Any other frame: go to WAIT_RSP, with the response counter cleared and the timeout timer cleared.
- WAIT_RSP: the number of expected response bytes depends on the frame type.
  - Read: 1 byte.
  - ALU frames: 2 bytes, LSB first.
- WAIT_RSP byte capture:
  - Each RX_D_VLD captures RX_P_DATA into the next byte lane of the response shift register.
  - Each RX_D_VLD also clears the timer.
  - After the final byte, go to DONE.
- WAIT_RSP timeout:
  - The timer increments every cycle without RX_D_VLD.
  - When the timer reaches TIMEOUT_CYCLES-1, go to IDLE. RSP_TIMEOUT is pulsed and RSP_DATA is set to 0.
- DONE:
  - RSP_VLD=1 for one cycle, then go to IDLE.
  - RSP_DATA contents: write → 0; read → {0, byte}; ALU → {byte1, byte0}.
- RSP_DATA holds its value until the next completion or timeout.
- RX_D_VLD outside WAIT_RSP is ignored.
- CMD_VLD outside IDLE is ignored; CMD_RDY=0.

## Timing

- Reset values at the first edge with RST=1:
  - FSM in IDLE.
  - CMD_RDY=1.
  - TX_D_VLD=0, TX_P_DATA=0.
  - RSP_DATA=0, RSP_VLD=0, RSP_TIMEOUT=0, BUSY=0.
  - Byte index, response counter and timer = 0.
- All outputs are registered or decoded from state only; there is no combinational path from input to output.
- Command accepted at edge N: TX_D_VLD=1 with byte 0 from cycle N+1.
- With TX_BUSY held at 0, a k-byte frame occupies cycles N+1..N+k.
- Write frame with TX_BUSY=0: RSP_VLD in cycle N+4.
- Response path: RSP_VLD is high in the cycle after the edge that samples the final RX_D_VLD.
- Back-to-back: CMD_RDY returns in the cycle after RSP_VLD or RSP_TIMEOUT. The minimum write-to-write spacing is 5 cycles.
- Simultaneous RX_D_VLD and terminal timer count: the byte wins and the timer clears.
- RST during any state abandons the frame.
  - No RSP_VLD or RSP_TIMEOUT is generated.
  - TX_D_VLD drops on the next edge.

## Test plan

- Reset, then write (addr=5, data=0x3C) with TX_BUSY=0 → TX bytes AA,05,3C on cycles N+1..N+3; RSP_VLD at N+4 with RSP_DATA=0.
- Read addr=2, with TX_BUSY high for 3 cycles on each byte → each byte held stable; after RX byte 0x7E, RSP_VLD with RSP_DATA=0x007E.
- ALU with operands, A=0x12, B=0x34, fun=1 → TX bytes CC,12,34,01; RX bytes 0x46,0x00 → RSP_DATA=0x0046.
- ALU without operands, fun=3 → TX bytes DD,03; with TIMEOUT_CYCLES=16, send only 1 RX byte → RSP_TIMEOUT 16 cycles after that byte, RSP_DATA=0, then CMD_RDY=1.
- Spurious RX_D_VLD while in IDLE and SEND → RSP_DATA unchanged, no RSP_VLD; CMD_VLD during SEND → not accepted.
- RST asserted for 1 cycle mid-SEND of a 0xCC frame → next cycle TX_D_VLD=0 and all outputs at reset values; a following read completes normally.
